// File: rtl/dds_seq_pkg.sv
// Shared types for the DDS note sequencer: FSM states, step-word layout
// and the step-word unpack helper.
package dds_seq_pkg;

  localparam int unsigned WORD_W   = 24;
  localparam int unsigned NOTE_W   = 8;
  localparam int unsigned FORM_W   = 3;
  localparam int unsigned PW_W     = 7;
  localparam int unsigned GLEN_W   = 6;
  localparam int unsigned TICKS_W  = 8;

  localparam int unsigned NOTE_LSB = 16;
  localparam int unsigned FORM_LSB = 13;
  localparam int unsigned PW_LSB   = 6;
  localparam int unsigned GLEN_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_APPLY = 2'd2,
    ST_PLAY  = 2'd3
  } state_e;

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [FORM_W-1:0] form;
    logic [PW_W-1:0]   pulse_width;
    logic [GLEN_W-1:0] gate_len;
  } step_t;

  function automatic step_t unpack_step(input logic [WORD_W-1:0] w);
    step_t s;
    s.note        = w[NOTE_LSB +: NOTE_W];
    s.form        = w[FORM_LSB +: FORM_W];
    s.pulse_width = w[PW_LSB   +: PW_W];
    s.gate_len    = w[GLEN_LSB +: GLEN_W];
    return s;
  endfunction

endpackage

// File: rtl/dds_note_sequencer_if.sv
// Host-side control/pattern-write bus and DDS-side outputs of the sequencer.
interface dds_note_sequencer_if #(
  parameter int unsigned STEPS = 16
) ();
  import dds_seq_pkg::*;

  localparam int unsigned ADDR_W = $clog2(STEPS);

  logic                start;
  logic                stop;
  logic                loop_en;
  logic [ADDR_W-1:0]   last_step;
  logic [TICKS_W-1:0]  step_ticks;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [WORD_W-1:0]   wr_data;

  logic [NOTE_W-1:0]   NOTE;
  logic [FORM_W-1:0]   form;
  logic [PW_W-1:0]     pulse_width;
  logic                gate;
  logic [ADDR_W-1:0]   step_idx;
  logic                busy;
  logic                done;

  modport master (
    output start, stop, loop_en, last_step, step_ticks, wr_en, wr_addr, wr_data,
    input  NOTE, form, pulse_width, gate, step_idx, busy, done
  );

  modport slave (
    input  start, stop, loop_en, last_step, step_ticks, wr_en, wr_addr, wr_data,
    output NOTE, form, pulse_width, gate, step_idx, busy, done
  );

endinterface

// File: rtl/dds_step_ram.sv
// Pattern memory: STEPS x 24, one write port, one registered read port,
// read-first on address collision, no reset.
module dds_step_ram
  import dds_seq_pkg::*;
#(
  parameter int unsigned STEPS  = 16,
  parameter int unsigned ADDR_W = $clog2(STEPS)
) (
  input  logic              CLK,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data_q
);

  logic [WORD_W-1:0] mem [STEPS];

  // Non-blocking read of mem gives the pre-write word on a same-address hit.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem[rd_addr];
  end

endmodule

// File: rtl/dds_note_sequencer.sv
// Step sequencer feeding NOTE/form/pulse_width and a gate to the DDS top,
// with tempo prescaler, per-step tick count, rests, looping and stop/start.
module dds_note_sequencer
  import dds_seq_pkg::*;
#(
  parameter int unsigned STEPS    = 16,
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic                 CLK,
  input  logic                 RESET,
  dds_note_sequencer_if.slave  bus
);

  localparam int unsigned ADDR_W = $clog2(STEPS);
  localparam int unsigned PRE_W  = $clog2(TICK_DIV);

  state_e              state_q, state_d;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [TICKS_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic [ADDR_W-1:0]   step_idx_q, step_idx_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic [FORM_W-1:0]   form_q, form_d;
  logic [PW_W-1:0]     pw_q, pw_d;
  logic [GLEN_W-1:0]   glen_q, glen_d;
  logic                gate_q, gate_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [WORD_W-1:0]   rd_data;
  step_t               step_c;
  logic                tick_c;
  logic [TICKS_W-1:0]  eff_ticks_c;
  logic [TICKS_W-1:0]  tick_nxt_c;

  dds_step_ram #(.STEPS(STEPS), .ADDR_W(ADDR_W)) u_ram (
    .CLK       (CLK),
    .wr_en     (bus.wr_en),
    .wr_addr   (bus.wr_addr),
    .wr_data   (bus.wr_data),
    .rd_en     (state_q == ST_FETCH),
    .rd_addr   (step_idx_q),
    .rd_data_q (rd_data)
  );

  assign step_c      = unpack_step(rd_data);
  assign tick_c      = (pre_q == PRE_W'(TICK_DIV - 1));
  assign eff_ticks_c = (bus.step_ticks == '0) ? TICKS_W'(1) : bus.step_ticks;
  assign tick_nxt_c  = tick_cnt_q + TICKS_W'(1);

  // Next-state and output-register logic.
  always_comb begin
    state_d    = state_q;
    pre_d      = pre_q;
    tick_cnt_d = tick_cnt_q;
    step_idx_d = step_idx_q;
    note_d     = note_q;
    form_d     = form_q;
    pw_d       = pw_q;
    glen_d     = glen_q;
    gate_d     = gate_q;
    done_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.stop) begin
          state_d    = ST_FETCH;
          step_idx_d = '0;
        end
      end
      ST_FETCH: state_d = ST_APPLY;
      ST_APPLY: begin
        if (step_c.note != '0) begin
          note_d = step_c.note;
          form_d = step_c.form;
          pw_d   = step_c.pulse_width;
        end
        gate_d     = (step_c.note != '0) && (step_c.gate_len != '0);
        glen_d     = step_c.gate_len;
        pre_d      = '0;
        tick_cnt_d = '0;
        state_d    = ST_PLAY;
      end
      ST_PLAY: begin
        pre_d = tick_c ? '0 : pre_q + PRE_W'(1);
        if (tick_c) begin
          tick_cnt_d = tick_nxt_c;
          if (tick_nxt_c == TICKS_W'(glen_q)) gate_d = 1'b0;
          if (tick_nxt_c == eff_ticks_c) begin
            if (step_idx_q != bus.last_step) begin
              step_idx_d = step_idx_q + ADDR_W'(1);
              state_d    = ST_FETCH;
            end else if (bus.loop_en) begin
              step_idx_d = '0;
              state_d    = ST_FETCH;
            end else begin
              done_d  = 1'b1;
              gate_d  = 1'b0;
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides everything else, including an end-of-step tick.
    if (state_q != ST_IDLE && bus.stop) begin
      state_d    = ST_IDLE;
      gate_d     = 1'b0;
      done_d     = 1'b0;
      note_d     = note_q;
      form_d     = form_q;
      pw_d       = pw_q;
      step_idx_d = step_idx_q;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= ST_IDLE;
      pre_q      <= '0;
      tick_cnt_q <= '0;
      step_idx_q <= '0;
      note_q     <= '0;
      form_q     <= '0;
      pw_q       <= '0;
      glen_q     <= '0;
      gate_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_q      <= pre_d;
      tick_cnt_q <= tick_cnt_d;
      step_idx_q <= step_idx_d;
      note_q     <= note_d;
      form_q     <= form_d;
      pw_q       <= pw_d;
      glen_q     <= glen_d;
      gate_q     <= gate_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.NOTE        = note_q;
  assign bus.form        = form_q;
  assign bus.pulse_width = pw_q;
  assign bus.gate        = gate_q;
  assign bus.step_idx    = step_idx_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: doc/dds_note_sequencer.md
# dds_note_sequencer

Step sequencer that drives the DDS synth top's control inputs (NOTE, form, pulse_width) from a small programmable pattern memory, and generates a gate for downstream envelope/mute logic. It sits between the host/register interface and the DDS top. It owns step timing (tempo prescaler plus per-step tick count), rests, looping and stop/start sequencing. The DDS datapath itself is unchanged.

## Interface
- STEPS, 16: pattern length capacity; power of 2; ADDR_W = log2(STEPS).
- TICK_DIV, 50000: CLK cycles per tempo tick; ≥ 2.
- CLK  in  1  system clock; all logic is rising-edge.
- RESET  in  1  reset, **asynchronous and active-low**.
- start  in  1  single-cycle request to begin playback at step 0.
- stop  in  1  single-cycle request to abort playback.
- loop_en  in  1  1 means wrap from last_step to step 0; 0 means finish after last_step.
- last_step  in  ADDR_W  index of the final step in the pattern.
- step_ticks  in  8  step length in ticks; the value 0 is treated as 1.
- wr_en  in  1  pattern write strobe.
- wr_addr  in  ADDR_W  pattern write address.
- wr_data  in  24  {note[23:16], form[15:13], pulse_width[12:6], gate_len[5:0]}.
- NOTE  out  8  note number to the DDS; note 0 denotes a rest.
- form  out  3  waveform select to the DDS.
- pulse_width  out  7  pulse width to the DDS.
- gate  out  1  note-sounding flag.
- step_idx  out  ADDR_W  index of the current step.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at the end of a non-looping pattern.

## Operation
- **States**
  - IDLE: waits for start.
  - FETCH: one cycle; issues a synchronous RAM read at step_idx.
  - APPLY: one cycle; latches the step's fields onto the outputs.
  - PLAY: counts ticks until the step length elapses.
- **IDLE → FETCH** on start. step_idx is set to 0.
- **APPLY → PLAY**, with these actions:
  - NOTE, form and pulse_width are loaded, unless note==0. For a rest, NOTE, form and pulse_width hold their previous values.
  - gate is set to 1 when note≠0 and gate_len≠0; otherwise gate is set to 0.
  - The tick prescaler and the tick counter are both cleared.
- **Prescaler** pulses once every TICK_DIV cycles while in PLAY.
- **gate fall:** gate drops on the tick where tick count reaches gate_len. If gate_len ≥ effective step_ticks, gate stays high for the whole step.
- **End of step** is the tick where tick count reaches the effective step_ticks:
  - If step_idx ≠ last_step: increment step_idx and go to FETCH.
  - If step_idx == last_step and loop_en=1: set step_idx to 0 and go to FETCH.
  - If step_idx == last_step and loop_en=0: pulse done for one cycle, set gate to 0, go to IDLE. step_idx holds.
- **stop** is accepted in any non-IDLE state. The next state is IDLE, gate goes to 0, and NOTE, form, pulse_width and step_idx hold. done is not pulsed.
- **start while busy** is ignored.
- **start and stop asserted together:** stop wins. If this happens in IDLE, the block stays in IDLE.
- **Pattern writes** are accepted in every state. The RAM is read-first: a write to the address being read in the same cycle returns the old data.
- The pattern RAM is not reset. The bench must program every step up to last_step before issuing start.
- **Reset:** all outputs go to 0, the state goes to IDLE and the prescaler is cleared. Reset asserted mid-playback aborts immediately and asynchronously.

## Timing
- With start sampled on edge k:
  - FETCH follows edge k.
  - The RAM data is registered on edge k+1.
  - Outputs and gate update on edge k+2.
- Step period in PLAY is effective_step_ticks × TICK_DIV cycles. Each step transition adds 2 cycles (FETCH + APPLY), so the total is step_ticks×TICK_DIV + 2 cycles.
- Gate high time is min(gate_len, effective step_ticks) × TICK_DIV cycles, measured from APPLY.
- done is asserted in the cycle after the final tick, and busy falls in the same cycle.
- All outputs are registered. There is no combinational path from input to output.

## Structure
- Package dds_seq_pkg contains:
  - the state enum;
  - field widths and bit positions of the step word (note, form, pulse_width, gate_len);
  - a function that unpacks a 24-bit word into the step fields.
- Sub-module dds_step_ram: STEPS×24, one write port and one synchronous read port, read-first, no reset.
- The top level holds the FSM, the prescaler, the tick counter and the output registers.

## Test plan
All scenarios use TICK_DIV=4.
- **Reset:** hold RESET=0 during activity, then release → all outputs 0, busy=0, and no activity until start.
- **Single pass:** program steps 0..2 as {69,2,40,2}, {72,1,64,4}, {0,0,0,3}. Set last_step=2, step_ticks=3, loop_en=0, then start.
  - NOTE is 69 at start+2 cycles, with gate high for 8 cycles.
  - NOTE is 72 with gate high for all 12 cycles of its step.
  - On the rest step, NOTE holds 72 and gate=0.
  - done pulses once, then busy=0.
- **Loop:** same pattern with loop_en=1 → step_idx sequence 0,1,2,0,1 with no done. Then pulse stop → IDLE next cycle, gate=0, NOTE holds.
- **Boundary:** step_ticks=0 and gate_len=63 → each step lasts 4+2 cycles and gate stays high through the step. Also set last_step=15 and check the wrap from 15 to 0.
- **Simultaneous events:** start and stop in the same cycle → stays IDLE. start while busy → ignored, step_idx unchanged. A write to the step currently in FETCH → old data applied, and the new data is applied on the next loop.
- **Async reset:** assert RESET mid-step, off a clock edge → outputs clear immediately. After release, start plays again from step 0.
